// File: rtl/gbdmg_vgm_player.sv
// gbdmg_vgm_player: decodes a VGM byte stream into shaped DMG APU register writes and sample-timed waits.
// Optional build macro GBDMG_VGM_SKIP_UNKNOWN_EN: unknown opcodes are skipped (error flagged) instead of halting.
module gbdmg_vgm_player #(
  parameter logic [15:0] CLK_PER_SAMPLE = 16'd95
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       out_ready,
  input  logic       in_pause,
  output logic [5:0] out_reg,
  output logic [7:0] out_val,
  output logic       out_wr,
  output logic       out_done,
  output logic       out_error
);

  typedef enum logic [2:0] {OP, ARG1, ARG2, WR_HI, WR_LO, WAIT, DONE, ERROR} state_t;

  localparam logic [15:0] PRESCALE_MAX = CLK_PER_SAMPLE - 16'd1;

  state_t      state, state_next;
  logic [7:0]  arg_lo;
  logic        cmd_wait;
  logic        cmd_wait_next;
  logic [15:0] sample_cnt;
  logic [15:0] prescale;
  logic [15:0] wait_n;
  logic        accept;
  logic        sample_end;
  logic        latch_cmd;
  logic        latch_arg;
  logic        load_write;
  logic        load_wait;
  logic        set_error;

  // Ready is gated by reset so nothing is accepted while the block is held in reset.
  assign out_ready  = in_rst_n && !in_pause && (state == OP || state == ARG1 || state == ARG2);
  assign accept     = in_valid && out_ready;
  assign out_wr     = (state == WR_HI);
  assign out_done   = (state == DONE);
  assign sample_end = !in_pause && (prescale == PRESCALE_MAX);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= OP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    cmd_wait_next = 1'b0;
    wait_n        = 16'd0;
    latch_cmd     = 1'b0;
    latch_arg     = 1'b0;
    load_write    = 1'b0;
    load_wait     = 1'b0;
    set_error     = 1'b0;
    case (state)
      OP: begin
        if (accept) begin
          casez (in_data)
            8'hB3: begin
              latch_cmd  = 1'b1;
              state_next = ARG1;
            end
            8'h61: begin
              latch_cmd     = 1'b1;
              cmd_wait_next = 1'b1;
              state_next    = ARG1;
            end
            8'h62: begin
              wait_n     = 16'd735;
              load_wait  = 1'b1;
              state_next = WAIT;
            end
            8'h63: begin
              wait_n     = 16'd882;
              load_wait  = 1'b1;
              state_next = WAIT;
            end
            8'b0111_????: begin
              wait_n     = {12'd0, in_data[3:0]} + 16'd1;
              load_wait  = 1'b1;
              state_next = WAIT;
            end
            8'h66: state_next = DONE;
            default: begin
              set_error = 1'b1;
`ifdef GBDMG_VGM_SKIP_UNKNOWN_EN
              state_next = OP;
`else
              state_next = ERROR;
`endif
            end
          endcase
        end
      end
      ARG1: begin
        if (accept) begin
          latch_arg  = 1'b1;
          state_next = ARG2;
        end
      end
      ARG2: begin
        if (accept) begin
          if (cmd_wait) begin
            wait_n = {in_data, arg_lo};
            if (wait_n == 16'd0) begin
              state_next = OP;
            end else begin
              load_wait  = 1'b1;
              state_next = WAIT;
            end
          end else if (arg_lo > 8'h3F) begin
            set_error  = 1'b1;
            state_next = OP;
          end else begin
            load_write = 1'b1;
            state_next = WR_HI;
          end
        end
      end
      WR_HI: state_next = WR_LO;
      WR_LO: state_next = OP;
      WAIT: begin
        if (sample_end && sample_cnt == 16'd1) begin
          state_next = OP;
        end
      end
      DONE:    state_next = DONE;
      ERROR:   state_next = ERROR;
      default: state_next = OP;
    endcase
  end

  // The prescaler counts in_clk cycles within one sample; the sample counter counts samples left.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      arg_lo     <= 8'd0;
      cmd_wait   <= 1'b0;
      sample_cnt <= 16'd0;
      prescale   <= 16'd0;
      out_reg    <= 6'd0;
      out_val    <= 8'd0;
      out_error  <= 1'b0;
    end else begin
      if (latch_cmd) begin
        cmd_wait <= cmd_wait_next;
      end
      if (latch_arg) begin
        arg_lo <= in_data;
      end
      if (load_write) begin
        out_reg <= arg_lo[5:0];
        out_val <= in_data;
      end
      if (set_error) begin
        out_error <= 1'b1;
      end
      if (load_wait) begin
        sample_cnt <= wait_n;
        prescale   <= 16'd0;
      end else if (state == WAIT && !in_pause) begin
        if (sample_end) begin
          prescale   <= 16'd0;
          sample_cnt <= sample_cnt - 16'd1;
        end else begin
          prescale <= prescale + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gbdmg_vgm_player.sv
// tb_gbdmg_vgm_player: scoreboard bench; commands push expected strobes / ready-return times, a monitor checks them.
module tb_gbdmg_vgm_player;

  localparam int CPS = 4;

  logic       in_clk = 1'b0;
  logic       in_rst_n = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_pause = 1'b0;
  logic       out_ready;
  logic [5:0] out_reg;
  logic [7:0] out_val;
  logic       out_wr;
  logic       out_done;
  logic       out_error;

  typedef struct {
    bit         isWrite;
    logic [5:0] regIdx;
    logic [7:0] val;
    int         at;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   fails = 0;
  int   cycle = 0;
  bit   monitorOn = 1'b0;
  bit   prevReady = 1'b0;
  bit   errExp = 1'b0;

  gbdmg_vgm_player #(.CLK_PER_SAMPLE(16'd4)) dut (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .in_pause (in_pause),
    .out_reg  (out_reg),
    .out_val  (out_val),
    .out_wr   (out_wr),
    .out_done (out_done),
    .out_error(out_error)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) cycle <= cycle + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Cycle label = number of rising edges seen; an event at label L is visible at the negedge after edge L.
  always @(negedge in_clk) begin
    exp_t e;
    if (monitorOn) begin
      if (out_wr) begin
        if (expQ.size() > 0 && expQ[0].isWrite) begin
          e = expQ.pop_front();
          checkOutput("wr_cycle", 32'(cycle), 32'(e.at));
          checkOutput("wr_reg", 32'(out_reg), 32'(e.regIdx));
          checkOutput("wr_val", 32'(out_val), 32'(e.val));
        end else begin
          checkOutput("spurious_wr", 32'(out_wr), 32'd0);
        end
      end
      if (out_ready && !prevReady) begin
        if (expQ.size() > 0 && !expQ[0].isWrite) begin
          e = expQ.pop_front();
          checkOutput("ready_return_cycle", 32'(cycle), 32'(e.at));
        end else begin
          checkOutput("spurious_ready_rise", 32'(out_ready), 32'(prevReady));
        end
      end
      while (expQ.size() > 0 && cycle > expQ[0].at) begin
        e = expQ.pop_front();
        checkOutput("missed_event", 32'(cycle), 32'(e.at));
      end
    end
    prevReady = out_ready;
  end

  // Called at a negedge; returns just after the accepting rising edge with its label in edgeIdx.
  task automatic sendByte(input logic [7:0] b, output int edgeIdx);
    int budget;
    budget = 3200;
    in_data  = b;
    in_valid = 1'b1;
    while (!out_ready && budget > 0) begin
      @(negedge in_clk);
      budget--;
    end
    if (!out_ready) begin
      checkOutput("accept_timeout", 32'(out_ready), 32'd1);
    end
    edgeIdx = cycle + 1;
    @(posedge in_clk);
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) @(negedge in_clk);
  endtask

  function automatic bit knownOp(input logic [7:0] op);
    return op == 8'hB3 || op == 8'h61 || op == 8'h62 || op == 8'h63 ||
           op == 8'h66 || op[7:4] == 4'h7;
  endfunction

  // Reference model: each command's bytes, its write (if any) and how long ready must stay low.
  task automatic applyStimulus(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2,
                               input int pauseAt, input int pauseLen);
    int e;
    int n;
    exp_t ev;
    n = 0;
    sendByte(op, e);
    if (op == 8'hB3 || op == 8'h61) begin
      @(negedge in_clk);
      sendByte(a1, e);
      @(negedge in_clk);
      sendByte(a2, e);
    end
    if (op == 8'hB3) begin
      if (a1 <= 8'h3F) begin
        ev = '{1'b1, a1[5:0], a2, e};
        expQ.push_back(ev);
        ev = '{1'b0, 6'd0, 8'd0, e + 2};
        expQ.push_back(ev);
      end else begin
        errExp = 1'b1;
      end
    end else if (op == 8'h61) begin
      n = int'({a2, a1});
    end else if (op == 8'h62) begin
      n = 735;
    end else if (op == 8'h63) begin
      n = 882;
    end else if (op[7:4] == 4'h7) begin
      n = int'(op[3:0]) + 1;
    end else if (!knownOp(op)) begin
      errExp = 1'b1;
    end
    if (n > 0) begin
      ev = '{1'b0, 6'd0, 8'd0, e + n * CPS + pauseLen};
      expQ.push_back(ev);
    end
    @(negedge in_clk);
    checkOutput("error_flag", 32'(out_error), 32'(errExp));
    if (pauseLen > 0) begin
      in_valid = 1'b0;
      repeat (pauseAt) @(negedge in_clk);
      in_pause = 1'b1;
      repeat (pauseLen) @(negedge in_clk);
      in_pause = 1'b0;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 4000;
    in_valid = 1'b0;
    while (expQ.size() > 0 && budget > 0) begin
      @(negedge in_clk);
      budget--;
    end
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
  endtask

  task automatic doReset();
    monitorOn = 1'b0;
    in_valid  = 1'b0;
    in_pause  = 1'b0;
    #1 in_rst_n = 1'b0;
    repeat (2) @(negedge in_clk);
    checkOutput("rst_out_reg", 32'(out_reg), 32'd0);
    checkOutput("rst_out_val", 32'(out_val), 32'd0);
    checkOutput("rst_out_wr", 32'(out_wr), 32'd0);
    checkOutput("rst_out_done", 32'(out_done), 32'd0);
    checkOutput("rst_out_error", 32'(out_error), 32'd0);
    checkOutput("rst_out_ready", 32'(out_ready), 32'd0);
    in_rst_n = 1'b1;
    expQ.delete();
    errExp = 1'b0;
    @(negedge in_clk);
    checkOutput("ready_after_release", 32'(out_ready), 32'd1);
    @(negedge in_clk);
    monitorOn = 1'b1;
  endtask

  initial begin
    int e;
    int r;
    int cnt;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] op;

    doReset();

    $display("[TB] directed write / wait streams");
    applyStimulus(8'hB3, 8'h02, 8'hF3, 0, 0);
    applyStimulus(8'h61, 8'h0A, 8'h00, 0, 0);
    applyStimulus(8'h61, 8'h00, 8'h00, 0, 0);
    applyStimulus(8'h7F, 8'h00, 8'h00, 0, 0);
    applyStimulus(8'h62, 8'h00, 8'h00, 0, 0);
    applyStimulus(8'hB3, 8'h45, 8'h11, 0, 0);
    applyStimulus(8'hB3, 8'h04, 8'h87, 0, 0);
    applyStimulus(8'h75, 8'h00, 8'h00, 5, 10);
    drain();

    $display("[TB] randomized command stream");
    repeat (40) begin
      r = $urandom_range(0, 9);
      a1 = 8'd0;
      a2 = 8'd0;
      if (r <= 4) begin
        op = 8'hB3;
        a1 = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
        a2 = 8'($urandom_range(0, 255));
      end else if (r <= 6) begin
        op = 8'h61;
        a1 = 8'($urandom_range(0, 12));
      end else begin
        op = {4'h7, 4'($urandom_range(0, 15))};
      end
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 3));
      end
      applyStimulus(op, a1, a2, 0, 0);
    end
    drain();

    $display("[TB] end-of-data");
    doReset();
    sendByte(8'h66, e);
    @(negedge in_clk);
    checkOutput("done_flag", 32'(out_done), 32'd1);
    checkOutput("done_ready", 32'(out_ready), 32'd0);

    $display("[TB] unknown opcode");
    doReset();
`ifdef GBDMG_VGM_SKIP_UNKNOWN_EN
    applyStimulus(8'h50, 8'h00, 8'h00, 0, 0);
    applyStimulus(8'hB3, 8'h01, 8'h80, 0, 0);
    drain();
`else
    sendByte(8'h50, e);
    @(negedge in_clk);
    checkOutput("unknown_error", 32'(out_error), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'hB3;
    cnt = 0;
    repeat (20) begin
      if (out_ready) cnt++;
      @(negedge in_clk);
    end
    checkOutput("unknown_stuck_ready", 32'(cnt), 32'd0);
`endif

    $display("[TB] reset during write strobe");
    doReset();
    monitorOn = 1'b0;
    sendByte(8'hB3, e);
    @(negedge in_clk);
    sendByte(8'h05, e);
    @(negedge in_clk);
    sendByte(8'hAA, e);
    #1;
    checkOutput("strobe_before_reset", 32'(out_wr), 32'd1);
    checkOutput("reg_before_reset", 32'(out_reg), 32'h05);
    #1 in_rst_n = 1'b0;
    #1;
    checkOutput("abort_out_wr", 32'(out_wr), 32'd0);
    checkOutput("abort_out_reg", 32'(out_reg), 32'd0);
    checkOutput("abort_out_val", 32'(out_val), 32'd0);
    checkOutput("abort_out_ready", 32'(out_ready), 32'd0);
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
